sample_loader: RTL and testbench

SAMPLE_LOADER -- requirements
Module: sample_loader

---
 rtl/sample_loader.sv | 150 +++++++++++++++
 tb/tb_sample_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// -----------------------------------------------------------------------------
// sample_loader
//
// Collects a frame of N = 2**ADDR_SIZE samples from an upstream valid/ready
// stream into a local buffer, then emits the frame as N/2 consecutive pairs
// (even address on port A, odd address on port B) to the bit_flip stage.
//
// Two-state FSM:
//   FILL : o_sample_ready=1, every accepted sample goes to buffer[wr_cnt].
//   EMIT : one pair per non-stalled clock, o_frame_done marks the last pair.
//
// Ports
//   i_CLK            single clock, rising edge
//   i_RST            synchronous active-high reset
//   i_sample_valid   upstream sample present
//   i_sample         upstream sample data (WORD_SIZE bits)
//   i_stall          downstream hold (only with SAMPLE_LOADER_STALL_EN)
//   o_sample_ready   loader accepts a sample this cycle
//   o_pipeaddr_A/B   pair addresses (ADDR_SIZE bits)
//   o_pipedata_A/B   pair data (WORD_SIZE bits)
//   o_pipe_valid     pair outputs valid this cycle
//   o_frame_done     one-cycle pulse alongside the last pair of a frame
//
// Configuration macro
//   SAMPLE_LOADER_STALL_EN : adds the i_stall port. When undefined the
//                            module behaves as if i_stall were tied to 0.
//
// ADDR_SIZE must be at least 2 so the pair counter has a non-zero width.
// -----------------------------------------------------------------------------
module sample_loader #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_sample_valid,
    input  logic [WORD_SIZE-1:0] i_sample,
`ifdef SAMPLE_LOADER_STALL_EN
    input  logic                 i_stall,
`endif
    output logic                 o_sample_ready,
    output logic [ADDR_SIZE-1:0] o_pipeaddr_A,
    output logic [ADDR_SIZE-1:0] o_pipeaddr_B,
    output logic [WORD_SIZE-1:0] o_pipedata_A,
    output logic [WORD_SIZE-1:0] o_pipedata_B,
    output logic                 o_pipe_valid,
    output logic                 o_frame_done
);

    localparam int N = 1 << ADDR_SIZE;
    localparam int PAIR_W = ADDR_SIZE - 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [ADDR_SIZE-1:0] LAST_SAMPLE = {ADDR_SIZE{1'b1}};
    localparam logic [PAIR_W-1:0]    LAST_PAIR   = {PAIR_W{1'b1}};
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE    = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
    localparam logic [PAIR_W-1:0]    PAIR_ONE    = {{(PAIR_W-1){1'b0}}, 1'b1};

    logic [0:0]           state_r;
    logic [ADDR_SIZE-1:0] wr_cnt_r;
    logic [PAIR_W-1:0]    pair_r;
    logic [WORD_SIZE-1:0] buf_r [0:N-1];

    logic                 stall_s;
    logic                 accept_s;
    logic [ADDR_SIZE-1:0] addr_a_s;
    logic [ADDR_SIZE-1:0] addr_b_s;

    // Downstream hold, tied low when the stall feature is not built in
    always_comb begin
`ifdef SAMPLE_LOADER_STALL_EN
        stall_s = i_stall;
`else
        stall_s = 1'b0;
`endif
    end

    // Ready is forced low during reset so nothing is accepted on a reset edge
    assign o_sample_ready = (state_r == FILL) & ~i_RST;
    assign accept_s       = i_sample_valid & o_sample_ready;
    assign addr_a_s       = {pair_r, 1'b0};
    assign addr_b_s       = {pair_r, 1'b1};

    // Sample buffer; contents survive reset, a new frame overwrites them
    always_ff @(posedge i_CLK) begin
        if (accept_s) begin
            buf_r[wr_cnt_r] <= i_sample;
        end
    end

    // FSM, write counter, pair counter and registered pair outputs
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r      <= FILL;
            wr_cnt_r     <= {ADDR_SIZE{1'b0}};
            pair_r       <= {PAIR_W{1'b0}};
            o_pipeaddr_A <= {ADDR_SIZE{1'b0}};
            o_pipeaddr_B <= {ADDR_SIZE{1'b0}};
            o_pipedata_A <= {WORD_SIZE{1'b0}};
            o_pipedata_B <= {WORD_SIZE{1'b0}};
            o_pipe_valid <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    o_pipe_valid <= 1'b0;
                    o_frame_done <= 1'b0;
                    if (accept_s) begin
                        if (wr_cnt_r == LAST_SAMPLE) begin
                            wr_cnt_r <= {ADDR_SIZE{1'b0}};
                            state_r  <= EMIT;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + ADDR_ONE;
                        end
                    end
                end
                EMIT: begin
                    if (stall_s) begin
                        // Hold addr/data and the pair index; just drop valid
                        o_pipe_valid <= 1'b0;
                        o_frame_done <= 1'b0;
                    end else begin
                        o_pipeaddr_A <= addr_a_s;
                        o_pipeaddr_B <= addr_b_s;
                        o_pipedata_A <= buf_r[addr_a_s];
                        o_pipedata_B <= buf_r[addr_b_s];
                        o_pipe_valid <= 1'b1;
                        o_frame_done <= (pair_r == LAST_PAIR);
                        if (pair_r == LAST_PAIR) begin
                            pair_r  <= {PAIR_W{1'b0}};
                            state_r <= FILL;
                        end else begin
                            pair_r <= pair_r + PAIR_ONE;
                        end
                    end
                end
                default: begin
                    state_r      <= FILL;
                    wr_cnt_r     <= {ADDR_SIZE{1'b0}};
                    pair_r       <= {PAIR_W{1'b0}};
                    o_pipe_valid <= 1'b0;
                    o_frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// -----------------------------------------------------------------------------
// tb_sample_loader
//
// Directed and randomized frames for sample_loader (WORD_SIZE=8, ADDR_SIZE=3).
// The reference is a plain array holding the frame being sent: pair k must
// carry addresses 2k/2k+1 and the array entries at those positions, and the
// last pair of every complete frame must carry frame_done.
// Stall steps are only exercised when SAMPLE_LOADER_STALL_EN is defined.
// -----------------------------------------------------------------------------
module tb_sample_loader;

    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_sample_valid = 1'b0;
    logic [7:0] i_sample = 8'd0;
    logic       i_stall = 1'b0;
    logic       o_sample_ready;
    logic [2:0] o_pipeaddr_A;
    logic [2:0] o_pipeaddr_B;
    logic [7:0] o_pipedata_A;
    logic [7:0] o_pipedata_B;
    logic       o_pipe_valid;
    logic       o_frame_done;

    int tests_run = 0;
    int tests_failed = 0;
    int done_seen = 0;
    int done_expected = 0;

    logic [7:0] model_buf [8];

    sample_loader #(.WORD_SIZE(8), .ADDR_SIZE(3)) dut (
        .i_CLK          (i_CLK),
        .i_RST          (i_RST),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
`ifdef SAMPLE_LOADER_STALL_EN
        .i_stall        (i_stall),
`endif
        .o_sample_ready (o_sample_ready),
        .o_pipeaddr_A   (o_pipeaddr_A),
        .o_pipeaddr_B   (o_pipeaddr_B),
        .o_pipedata_A   (o_pipedata_A),
        .o_pipedata_B   (o_pipedata_B),
        .o_pipe_valid   (o_pipe_valid),
        .o_frame_done   (o_frame_done)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic set_frame_seq(input int base);
        for (int i = 0; i < 8; i++) model_buf[i] = 8'(base + i);
    endtask

    task automatic set_frame_rand();
        for (int i = 0; i < 8; i++) model_buf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addrA"}, 32'(o_pipeaddr_A), 32'd0);
        check({tag, "_addrB"}, 32'(o_pipeaddr_B), 32'd0);
        check({tag, "_dataA"}, 32'(o_pipedata_A), 32'd0);
        check({tag, "_dataB"}, 32'(o_pipedata_B), 32'd0);
        check({tag, "_valid"}, 32'(o_pipe_valid), 32'd0);
        check({tag, "_done"},  32'(o_frame_done), 32'd0);
    endtask

    // gap_mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps
    task automatic fill_frame(input int gap_mode);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        while (idx < 8 && cyc < 64) begin
            check("ready_fill", 32'(o_sample_ready), 32'd1);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_sample_valid = v;
            i_sample = v ? model_buf[idx] : 8'($urandom_range(0, 255));
            tick();
            if (v) idx++;
            check("valid_during_fill", 32'(o_pipe_valid), 32'd0);
            cyc++;
        end
        check("fill_count", 32'(idx), 32'd8);
        i_sample_valid = 1'b0;
    endtask

    // Emits npairs pairs; junk sample 99 is offered throughout EMIT
    task automatic emit_pairs(input int npairs, input int stall_at);
        for (int k = 0; k < npairs; k++) begin
            check("ready_emit", 32'(o_sample_ready), 32'd0);
            i_sample_valid = 1'b1;
            i_sample = 8'd99;
            tick();
            check("pair_valid", 32'(o_pipe_valid), 32'd1);
            check("pair_addrA", 32'(o_pipeaddr_A), 32'(2 * k));
            check("pair_addrB", 32'(o_pipeaddr_B), 32'(2 * k + 1));
            check("pair_dataA", 32'(o_pipedata_A), 32'(model_buf[2 * k]));
            check("pair_dataB", 32'(o_pipedata_B), 32'(model_buf[2 * k + 1]));
            check("pair_done", 32'(o_frame_done), 32'(k == 3));
            if (o_frame_done === 1'b1) done_seen++;
`ifdef SAMPLE_LOADER_STALL_EN
            if (k == stall_at && k < 3) begin
                i_stall = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    check("stall_valid", 32'(o_pipe_valid), 32'd0);
                    check("stall_done", 32'(o_frame_done), 32'd0);
                    check("stall_addrA", 32'(o_pipeaddr_A), 32'(2 * k));
                    check("stall_dataB", 32'(o_pipedata_B), 32'(model_buf[2 * k + 1]));
                end
                i_stall = 1'b0;
            end
`else
            if (k == stall_at) i_stall = 1'b0;
`endif
        end
        i_sample_valid = 1'b0;
        if (npairs == 4) begin
            done_expected++;
            check("ready_after_frame", 32'(o_sample_ready), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        i_RST = 1'b1;
        tick();
        tick();
        check("ready_in_reset", 32'(o_sample_ready), 32'd0);
        check_all_zero("reset");
        i_RST = 1'b0;
        #1;
        check("ready_after_reset", 32'(o_sample_ready), 32'd1);

        // Back-to-back frame 10..17
        set_frame_seq(10);
        fill_frame(0);
        emit_pairs(4, -1);

        // Idle cycle: valid/done low, last pair held
        tick();
        check("idle_valid", 32'(o_pipe_valid), 32'd0);
        check("idle_done", 32'(o_frame_done), 32'd0);
        check("idle_addrA", 32'(o_pipeaddr_A), 32'd6);
        check("idle_addrB", 32'(o_pipeaddr_B), 32'd7);
        check("idle_dataA", 32'(o_pipedata_A), 32'd16);
        check("idle_dataB", 32'(o_pipedata_B), 32'd17);

        // Gapped frame 20..27
        set_frame_seq(20);
        fill_frame(1);
        emit_pairs(4, -1);

        // Two frames back to back
        set_frame_seq(10);
        fill_frame(0);
        emit_pairs(4, -1);
        set_frame_seq(30);
        fill_frame(0);
        emit_pairs(4, -1);

        // Reset after pair (2,3,12,13), then frame 40..47
        set_frame_seq(10);
        fill_frame(0);
        emit_pairs(2, -1);
        i_RST = 1'b1;
        #1;
        check("ready_mid_reset", 32'(o_sample_ready), 32'd0);
        tick();
        check_all_zero("midreset");
        i_RST = 1'b0;
        #1;
        check("ready_post_midreset", 32'(o_sample_ready), 32'd1);
        set_frame_seq(40);
        fill_frame(0);
        emit_pairs(4, -1);

        // Randomized frames, gaps and stall points
        for (int f = 0; f < 6; f++) begin
            set_frame_rand();
            fill_frame(2);
            emit_pairs(4, int'($urandom_range(0, 3)));
        end

        // Stall after pair (2,3,12,13)
        set_frame_seq(10);
        fill_frame(0);
        emit_pairs(4, 1);

        tick();
        check("done_pulse_count", 32'(done_seen), 32'(done_expected));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
